// File: rtl/fir_csd_tdm.sv
// Time-multiplexed multi-channel FIR: one CSD shift-add tap per clock,
// per-channel circular delay lines, double-banked coefficients with deferred swap.
module fir_csd_tdm #(
  parameter int I_WIDTH   = 16,
  parameter int O_WIDTH   = 16,
  parameter int ORDER     = 17,
  parameter int N_SHIFT   = 9,
  parameter int N_CH      = 2,
  parameter int OUT_SHIFT = 9,
  localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int A_W       = (ORDER > 1) ? $clog2(ORDER) : 1,
  localparam int ACC_WIDTH = I_WIDTH + N_SHIFT + $clog2(ORDER) + 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_valid,
  output logic                      o_ready,
  input  logic [CH_W-1:0]           i_ch,
  input  logic [I_WIDTH-1:0]        i_data,
  input  logic                      i_coef_we,
  input  logic [A_W-1:0]            i_coef_addr,
  input  logic [2*N_SHIFT-1:0]      i_coef_data,
  input  logic                      i_coef_swap,
  output logic                      o_valid,
  output logic [CH_W-1:0]           o_ch,
  output logic [O_WIDTH-1:0]        o_data,
  output logic                      o_sat
);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_OUTPUT} state_t;

  localparam logic [A_W-1:0] LAST = A_W'(ORDER - 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-O_WIDTH+1){1'b0}}, {(O_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

  state_t                       r_state, w_state_nxt;
  logic [I_WIDTH-1:0]           r_line [N_CH][ORDER];
  logic [A_W-1:0]               r_ptr  [N_CH];
  logic [2*N_SHIFT-1:0]         r_coef [2][ORDER];
  logic                         r_sel, r_pend;
  logic [CH_W-1:0]              r_ch;
  logic [A_W-1:0]               r_k, r_idx;
  logic signed [ACC_WIDTH-1:0]  r_acc;

  logic                         w_accept, w_last_k, w_swap_req, w_sat;
  logic [I_WIDTH-1:0]           w_sample;
  logic [2*N_SHIFT-1:0]         w_coef;
  logic signed [ACC_WIDTH-1:0]  w_x_ext, w_prod, w_shifted;
  logic [O_WIDTH-1:0]           w_sat_data;

  // Handshake: a sample transfers on an edge where i_valid && o_ready; o_ready is
  // high only in IDLE, and samples offered at other times are neither taken nor queued.
  assign o_ready    = (r_state == S_IDLE);
  assign w_accept   = o_ready && i_valid && (32'(i_ch) < N_CH);
  assign w_last_k   = (r_k == LAST);
  assign w_swap_req = r_pend | i_coef_swap;
  assign w_sample   = r_line[r_ch][r_idx];
  assign w_coef     = r_coef[r_sel][r_k];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_state_nxt = S_ACCUM;
      S_ACCUM:  if (w_last_k) w_state_nxt = S_OUTPUT;
      S_OUTPUT: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_x_ext = {{(ACC_WIDTH-I_WIDTH){w_sample[I_WIDTH-1]}}, w_sample};
    w_prod  = '0;
    for (int j = 0; j < N_SHIFT; j++) begin
      case (w_coef[2*j +: 2])
        2'b01:   w_prod = w_prod + (w_x_ext <<< j);
        2'b11:   w_prod = w_prod - (w_x_ext <<< j);
        default: ;
      endcase
    end
  end

  always_comb begin
    w_shifted  = r_acc >>> OUT_SHIFT;
    w_sat      = 1'b0;
    w_sat_data = w_shifted[O_WIDTH-1:0];
    if (w_shifted > SAT_MAX) begin
      w_sat      = 1'b1;
      w_sat_data = {1'b0, {(O_WIDTH-1){1'b1}}};
    end else if (w_shifted < SAT_MIN) begin
      w_sat      = 1'b1;
      w_sat_data = {1'b1, {(O_WIDTH-1){1'b0}}};
    end
  end

  // Writes always target the bank that is shadow before the edge; a pending swap
  // only lands in IDLE so an in-flight accumulation never sees mixed banks.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int b = 0; b < 2; b++)
        for (int a = 0; a < ORDER; a++) r_coef[b][a] <= '0;
      r_sel  <= 1'b0;
      r_pend <= 1'b0;
    end else begin
      if (i_coef_we && (32'(i_coef_addr) < ORDER))
        r_coef[~r_sel][i_coef_addr] <= i_coef_data;
      if ((r_state == S_IDLE) && w_swap_req) begin
        r_sel  <= ~r_sel;
        r_pend <= 1'b0;
      end else begin
        r_pend <= w_swap_req;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int c = 0; c < N_CH; c++) begin
        for (int a = 0; a < ORDER; a++) r_line[c][a] <= '0;
        r_ptr[c] <= '0;
      end
      r_ch    <= '0;
      r_k     <= '0;
      r_idx   <= '0;
      r_acc   <= '0;
      o_valid <= 1'b0;
      o_ch    <= '0;
      o_data  <= '0;
      o_sat   <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_line[i_ch][r_ptr[i_ch]] <= i_data;
            r_ch  <= i_ch;
            r_idx <= r_ptr[i_ch];
            r_k   <= '0;
            r_acc <= '0;
          end
        end
        S_ACCUM: begin
          r_acc <= r_acc + w_prod;
          r_idx <= (r_idx == '0) ? LAST : r_idx - 1'b1;
          r_k   <= w_last_k ? '0 : r_k + 1'b1;
          if (w_last_k)
            r_ptr[r_ch] <= (r_ptr[r_ch] == LAST) ? '0 : r_ptr[r_ch] + 1'b1;
        end
        S_OUTPUT: begin
          o_valid <= 1'b1;
          o_ch    <= r_ch;
          o_data  <= w_sat_data;
          o_sat   <= w_sat;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_csd_tdm.sv
// Directed bench for fir_csd_tdm: vector table, reference model with scoreboard,
// and hand sequences for swap timing, backpressure, invalid channel and reset.
module tb_fir_csd_tdm;

  localparam int ORDER = 17;
  localparam int N_CH  = 3;
  localparam int CH_W  = 2;
  localparam int A_W   = 5;
  localparam int CW    = 18;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            i_valid = 1'b0;
  logic            o_ready;
  logic [CH_W-1:0] i_ch = '0;
  logic [15:0]     i_data = '0;
  logic            i_coef_we = 1'b0;
  logic [A_W-1:0]  i_coef_addr = '0;
  logic [CW-1:0]   i_coef_data = '0;
  logic            i_coef_swap = 1'b0;
  logic            o_valid;
  logic [CH_W-1:0] o_ch;
  logic [15:0]     o_data;
  logic            o_sat;

  fir_csd_tdm #(.N_CH(N_CH)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_ch(i_ch), .i_data(i_data), .i_coef_we(i_coef_we),
    .i_coef_addr(i_coef_addr), .i_coef_data(i_coef_data),
    .i_coef_swap(i_coef_swap), .o_valid(o_valid), .o_ch(o_ch),
    .o_data(o_data), .o_sat(o_sat)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;
  int n_results = 0;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int m_line [N_CH][ORDER];
  int m_ptr  [N_CH];
  int m_coef [2][ORDER];
  int m_sel;
  bit m_pend;
  logic [18:0] exp_q[$];
  int          acc_q[$];

  function automatic int csd_val(input logic [CW-1:0] w);
    int v = 0;
    for (int j = 0; j < 9; j++) begin
      if (w[2*j +: 2] == 2'b01) v += (1 << j);
      else if (w[2*j +: 2] == 2'b11) v -= (1 << j);
    end
    return v;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < N_CH; c++) begin
      m_ptr[c] = 0;
      for (int a = 0; a < ORDER; a++) m_line[c][a] = 0;
    end
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < ORDER; a++) m_coef[b][a] = 0;
    m_sel = 0;
    m_pend = 0;
    exp_q.delete();
    acc_q.delete();
  endtask

  // Called at the negedge before the edge that accepts the sample.
  task automatic model_accept(input int ch, input int d);
    longint y = 0;
    int r, s;
    logic [15:0] r16;
    logic [1:0]  c2;
    if (m_pend) begin m_sel ^= 1; m_pend = 0; end
    if (ch >= N_CH) return;
    m_line[ch][m_ptr[ch]] = d;
    for (int k = 0; k < ORDER; k++)
      y += longint'(m_coef[m_sel][k]) * longint'(m_line[ch][(m_ptr[ch] - k + ORDER) % ORDER]);
    m_ptr[ch] = (m_ptr[ch] + 1) % ORDER;
    y = y >>> 9;
    if (y > 32767) begin r = 32767; s = 1; end
    else if (y < -32768) begin r = -32768; s = 1; end
    else begin r = int'(y); s = 0; end
    r16 = r[15:0];
    c2 = ch[1:0];
    exp_q.push_back({c2, s[0], r16});
    acc_q.push_back(cyc + 1);
  endtask

  // ---------------- scoreboard monitor ----------------
  logic [18:0] sb_e;
  int          sb_t;
  always @(negedge clk) begin
    if (rst_n && o_valid) begin
      n_results++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sb_unexpected: got o_valid=1 data %0d expected no result", $signed(o_data));
      end else begin
        sb_e = exp_q.pop_front();
        sb_t = acc_q.pop_front();
        check("sb_data", int'($signed(o_data)), int'($signed(sb_e[15:0])));
        check("sb_ch", int'(o_ch), int'(sb_e[18:17]));
        check("sb_sat", int'(o_sat), int'(sb_e[16]));
        check("sb_latency", cyc - sb_t, 18);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic write_coef(input int addr, input logic [CW-1:0] w);
    @(negedge clk);
    i_coef_we = 1'b1;
    i_coef_addr = addr[A_W-1:0];
    i_coef_data = w;
    m_coef[1 - m_sel][addr] = csd_val(w);
    @(negedge clk);
    i_coef_we = 1'b0;
  endtask

  task automatic swap_idle();
    @(negedge clk);
    i_coef_swap = 1'b1;
    m_sel ^= 1;
    @(negedge clk);
    i_coef_swap = 1'b0;
  endtask

  task automatic wait_result(input string name, output int gd, output int gc, output int gs);
    int n = 0;
    gd = 0; gc = 0; gs = 0;
    while (!o_valid && n < 40) begin @(negedge clk); n++; end
    if (o_valid) begin
      gd = int'($signed(o_data));
      gc = int'(o_ch);
      gs = int'(o_sat);
    end else begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_timeout: got no o_valid expected result within 40 cycles", name);
    end
  endtask

  task automatic accept(input int ch, input int d);
    int n = 0;
    @(negedge clk);
    while (!o_ready && n < 50) begin @(negedge clk); n++; end
    if (!o_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL ready_timeout: got o_ready=0 expected 1");
    end
    i_valid = 1'b1;
    i_ch = ch[CH_W-1:0];
    i_data = d[15:0];
    model_accept(ch, d);
    @(negedge clk);
    i_valid = 1'b0;
  endtask

  task automatic send(input int ch, input int d, output int gd, output int gc, output int gs);
    accept(ch, d);
    wait_result("send", gd, gc, gs);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    int ch;
    int din;
    int exp_data;
    int exp_sat;
  } vec_t;

  vec_t vecs[7];
  int gd, gc, gs, hs, low, base;

  initial begin
    vecs[0] = '{0, 512, 256, 0};
    vecs[1] = '{0, 0, -128, 0};
    vecs[2] = '{0, 0, 0, 0};
    vecs[3] = '{0, 512, 256, 0};
    vecs[4] = '{1, 1024, 512, 0};
    vecs[5] = '{0, 0, -128, 0};
    vecs[6] = '{1, 0, -256, 0};
    model_reset();

    // reset state
    repeat (3) @(negedge clk);
    check("rst_valid", int'(o_valid), 0);
    check("rst_data", int'(o_data), 0);
    check("rst_sat", int'(o_sat), 0);
    check("rst_ch", int'(o_ch), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", int'(o_ready), 1);

    // impulse response and channel isolation
    write_coef(0, 18'h10000);
    write_coef(1, 18'h0C000);
    swap_idle();
    for (int i = 0; i < 7; i++) begin
      send(vecs[i].ch, vecs[i].din, gd, gc, gs);
      check($sformatf("vec%0d_data", i), gd, vecs[i].exp_data);
      check($sformatf("vec%0d_ch", i), gc, vecs[i].ch);
      check($sformatf("vec%0d_sat", i), gs, vecs[i].exp_sat);
    end

    // saturation, both rails and recovery
    for (int a = 0; a < ORDER; a++) write_coef(a, 18'h15555);
    swap_idle();
    for (int i = 0; i < ORDER; i++) send(0, 32767, gd, gc, gs);
    check("sat_pos_data", gd, 32767);
    check("sat_pos_flag", gs, 1);
    for (int i = 0; i < ORDER; i++) send(0, -32768, gd, gc, gs);
    check("sat_neg_data", gd, -32768);
    check("sat_neg_flag", gs, 1);
    for (int i = 0; i < ORDER; i++) send(0, 0, gd, gc, gs);
    check("sat_zero_data", gd, 0);
    check("sat_zero_flag", gs, 0);

    // swap requested mid-accumulation
    write_coef(0, 18'h10000);
    for (int a = 1; a < ORDER; a++) write_coef(a, 18'h00000);
    swap_idle();
    for (int a = 1; a < ORDER; a++) write_coef(a, 18'h00000);
    accept(0, 512);
    repeat (4) @(negedge clk);
    i_coef_we = 1'b1;
    i_coef_addr = '0;
    i_coef_data = 18'h04000;
    i_coef_swap = 1'b1;
    m_coef[1 - m_sel][0] = 128;
    m_pend = 1;
    @(negedge clk);
    i_coef_we = 1'b0;
    i_coef_swap = 1'b0;
    wait_result("swap_inflight", gd, gc, gs);
    check("swap_inflight_data", gd, 256);
    send(0, 512, gd, gc, gs);
    check("swap_next_data", gd, 128);

    // held valid: one result per 19 cycles, ready low while busy
    write_coef(1, 18'h0C000);
    swap_idle();
    @(negedge clk);
    base = n_results;
    hs = 0;
    low = 0;
    i_valid = 1'b1;
    i_ch = 2'd1;
    i_data = 16'd1000;
    for (int i = 0; i < 38; i++) begin
      if (o_ready) begin hs++; model_accept(1, 1000); end
      else low++;
      @(negedge clk);
    end
    i_valid = 1'b0;
    check("hold_handshakes", hs, 2);
    check("hold_ready_low", low, 36);
    repeat (25) @(negedge clk);
    check("hold_results", n_results - base, 2);

    // invalid channel is consumed without effect
    base = n_results;
    i_valid = 1'b1;
    i_ch = 2'd3;
    i_data = 16'd7777;
    model_accept(3, 7777);
    @(negedge clk);
    i_valid = 1'b0;
    check("badch_ready", int'(o_ready), 1);
    repeat (25) @(negedge clk);
    check("badch_no_result", n_results - base, 0);
    send(1, 0, gd, gc, gs);
    check("badch_line_intact", gd, -250);
    check("badch_ch", gc, 1);

    // asynchronous reset during accumulation
    accept(0, 512);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_valid", int'(o_valid), 0);
    check("arst_data", int'(o_data), 0);
    check("arst_ch", int'(o_ch), 0);
    check("arst_ready", int'(o_ready), 1);
    model_reset();
    base = n_results;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    check("arst_no_result", n_results - base, 0);
    send(0, 512, gd, gc, gs);
    check("arst_coefs_cleared", gd, 0);
    check("arst_sat", gs, 0);

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
